// File: rtl/axi_r_resp_router.sv
// AXI read-response router: two slave R ports to two master R ports, burst-locked round-robin.
// Optional protocol checker (RID stability, 256-beat limit) enabled with AXI_R_RESP_CHECK_EN.
module axi_r_resp_router #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ID_WIDTH:0]     RID_S0,
   input  logic [DATA_WIDTH-1:0] RDATA_S0,
   input  logic [1:0]            RRESP_S0,
   input  logic                  RLAST_S0,
   input  logic                  RVALID_S0,
   output logic                  RREADY_S0,

   input  logic [ID_WIDTH:0]     RID_S1,
   input  logic [DATA_WIDTH-1:0] RDATA_S1,
   input  logic [1:0]            RRESP_S1,
   input  logic                  RLAST_S1,
   input  logic                  RVALID_S1,
   output logic                  RREADY_S1,

   output logic [ID_WIDTH-1:0]   RID_M0,
   output logic [DATA_WIDTH-1:0] RDATA_M0,
   output logic [1:0]            RRESP_M0,
   output logic                  RLAST_M0,
   output logic                  RVALID_M0,
   input  logic                  RREADY_M0,

   output logic [ID_WIDTH-1:0]   RID_M1,
   output logic [DATA_WIDTH-1:0] RDATA_M1,
   output logic [1:0]            RRESP_M1,
   output logic                  RLAST_M1,
   output logic                  RVALID_M1,
   input  logic                  RREADY_M1,

   output logic                  prot_err
);

   typedef enum logic {StIdle, StBurst} state_e;

   state_e state_q, state_d;
   logic   ptr_q, ptr_d;
   logic   sel_slave_q, sel_slave_d;
   logic   sel_master_q, sel_master_d;
   logic   grant;

   logic [ID_WIDTH:0]     s_id;
   logic [DATA_WIDTH-1:0] s_data;
   logic [1:0]            s_resp;
   logic                  s_last;
   logic                  s_valid;
   logic                  m_ready;
   logic                  beat_hs;

   always_comb begin
      s_id    = sel_slave_q ? RID_S1    : RID_S0;
      s_data  = sel_slave_q ? RDATA_S1  : RDATA_S0;
      s_resp  = sel_slave_q ? RRESP_S1  : RRESP_S0;
      s_last  = sel_slave_q ? RLAST_S1  : RLAST_S0;
      s_valid = sel_slave_q ? RVALID_S1 : RVALID_S0;
      m_ready = sel_master_q ? RREADY_M1 : RREADY_M0;
      beat_hs = (state_q == StBurst) & s_valid & m_ready;
   end

   // ptr_q=1 means S1 is preferred when both slaves request
   always_comb begin
      if (RVALID_S0 && RVALID_S1) begin
         grant = ptr_q;
      end else begin
         grant = RVALID_S1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         ptr_q        <= 1'b0;
         sel_slave_q  <= 1'b0;
         sel_master_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         sel_slave_q  <= sel_slave_d;
         sel_master_q <= sel_master_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      sel_slave_d  = sel_slave_q;
      sel_master_d = sel_master_q;
      case (state_q)
         StIdle: begin
            if (RVALID_S0 || RVALID_S1) begin
               state_d      = StBurst;
               sel_slave_d  = grant;
               sel_master_d = grant ? RID_S1[ID_WIDTH] : RID_S0[ID_WIDTH];
            end
         end
         StBurst: begin
            if (beat_hs && s_last) begin
               state_d = StIdle;
               ptr_d   = ~sel_slave_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      RID_M0    = '0;
      RDATA_M0  = '0;
      RRESP_M0  = '0;
      RLAST_M0  = 1'b0;
      RVALID_M0 = 1'b0;
      RID_M1    = '0;
      RDATA_M1  = '0;
      RRESP_M1  = '0;
      RLAST_M1  = 1'b0;
      RVALID_M1 = 1'b0;
      RREADY_S0 = 1'b0;
      RREADY_S1 = 1'b0;
      if (state_q == StBurst) begin
         if (!sel_master_q) begin
            RID_M0    = s_id[ID_WIDTH-1:0];
            RDATA_M0  = s_data;
            RRESP_M0  = s_resp;
            RLAST_M0  = s_last;
            RVALID_M0 = s_valid;
         end else begin
            RID_M1    = s_id[ID_WIDTH-1:0];
            RDATA_M1  = s_data;
            RRESP_M1  = s_resp;
            RLAST_M1  = s_last;
            RVALID_M1 = s_valid;
         end
         if (!sel_slave_q) begin
            RREADY_S0 = m_ready;
         end else begin
            RREADY_S1 = m_ready;
         end
      end
   end

`ifdef AXI_R_RESP_CHECK_EN
   logic [7:0]        beat_cnt_q;
   logic [ID_WIDTH:0] rid_q;
   logic              prot_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt_q <= 8'd0;
         rid_q      <= '0;
         prot_err_q <= 1'b0;
      end else begin
         if (state_q == StIdle && state_d == StBurst) begin
            beat_cnt_q <= 8'd0;
            rid_q      <= grant ? RID_S1 : RID_S0;
         end else if (beat_hs && !s_last) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
         end
         // 256th beat without RLAST, or RID drifting inside the burst
         if (beat_hs && ((s_id != rid_q) || (!s_last && beat_cnt_q == 8'hff))) begin
            prot_err_q <= 1'b1;
         end
      end
   end

   assign prot_err = prot_err_q;
`else
   assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_r_resp_router.sv
// Self-checking bench for axi_r_resp_router: vector table, hand sequences, randomized traffic.
module tb_axi_r_resp_router;

   logic        clk;
   logic        rst;
   logic [4:0]  rid_s0, rid_s1;
   logic [31:0] rdata_s0, rdata_s1;
   logic [1:0]  rresp_s0, rresp_s1;
   logic        rlast_s0, rlast_s1, rvalid_s0, rvalid_s1;
   logic        rready_s0, rready_s1;
   logic [3:0]  rid_m0, rid_m1;
   logic [31:0] rdata_m0, rdata_m1;
   logic [1:0]  rresp_m0, rresp_m1;
   logic        rlast_m0, rlast_m1, rvalid_m0, rvalid_m1;
   logic        rready_m0, rready_m1;
   logic        prot_err;

`ifdef AXI_R_RESP_CHECK_EN
   localparam bit ExpErr = 1'b1;
`else
   localparam bit ExpErr = 1'b0;
`endif

   axi_r_resp_router #(.ID_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .RID_S0(rid_s0), .RDATA_S0(rdata_s0), .RRESP_S0(rresp_s0), .RLAST_S0(rlast_s0),
      .RVALID_S0(rvalid_s0), .RREADY_S0(rready_s0),
      .RID_S1(rid_s1), .RDATA_S1(rdata_s1), .RRESP_S1(rresp_s1), .RLAST_S1(rlast_s1),
      .RVALID_S1(rvalid_s1), .RREADY_S1(rready_s1),
      .RID_M0(rid_m0), .RDATA_M0(rdata_m0), .RRESP_M0(rresp_m0), .RLAST_M0(rlast_m0),
      .RVALID_M0(rvalid_m0), .RREADY_M0(rready_m0),
      .RID_M1(rid_m1), .RDATA_M1(rdata_m1), .RRESP_M1(rresp_m1), .RLAST_M1(rlast_m1),
      .RVALID_M1(rvalid_m1), .RREADY_M1(rready_m1),
      .prot_err(prot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      bit          rb;
      bit          v0;
      bit          l0;
      logic [4:0]  i0;
      logic [31:0] d0;
      bit          v1;
      bit          l1;
      logic [4:0]  i1;
      logic [31:0] d1;
      bit          r0;
      bit          r1;
      logic [5:0]  ctl;  // {vm0, vm1, rs0, rs1, lm0, lm1}
      logic [3:0]  ei0;
      logic [3:0]  ei1;
      logic [31:0] ed0;
      logic [31:0] ed1;
   } vec_t;

   function automatic vec_t row(input bit rb, input bit v0, input bit l0, input logic [4:0] i0,
                                input logic [31:0] d0, input bit v1, input bit l1,
                                input logic [4:0] i1, input logic [31:0] d1, input bit r0,
                                input bit r1, input logic [5:0] ctl, input logic [3:0] ei0,
                                input logic [3:0] ei1, input logic [31:0] ed0,
                                input logic [31:0] ed1);
      vec_t v;
      v.rb = rb; v.v0 = v0; v.l0 = l0; v.i0 = i0; v.d0 = d0;
      v.v1 = v1; v.l1 = l1; v.i1 = i1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
      v.ctl = ctl; v.ei0 = ei0; v.ei1 = ei1; v.ed0 = ed0; v.ed1 = ed1;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic idle_inputs();
      rid_s0 = '0; rdata_s0 = '0; rresp_s0 = '0; rlast_s0 = 1'b0; rvalid_s0 = 1'b0;
      rid_s1 = '0; rdata_s1 = '0; rresp_s1 = '0; rlast_s1 = 1'b0; rvalid_s1 = 1'b0;
      rready_m0 = 1'b0; rready_m1 = 1'b0;
   endtask

   localparam int NRows = 23;
   localparam int NB    = 40;
   vec_t tbl [NRows];

   logic        sv [2];
   logic        sl [2];
   logic [4:0]  sid [2];
   logic [31:0] sd [2];
   logic [1:0]  sr [2];
   int          rem [2];
   int          bursts [2];
   logic        hs_s [2];
   logic        mhs [2];
   int          owner;
   int          src;
   int          cyc;
   logic [38:0] got_beat;

   initial begin
      rst = 1'b0;
      idle_inputs();
      #3;
      chk("reset_state", {rvalid_m0, rvalid_m1, rready_s0, rready_s1, prot_err, rid_m0, rid_m1,
                          rdata_m0, rdata_m1}, '0);
      @(posedge clk);
      #1 rst = 1'b1;

      //          rb v0 l0 i0     d0      v1 l1 i1     d1      r0 r1 ctl        ei0 ei1 ed0 ed1
      tbl[0]  = row(0, 1, 0, 5'h13, 32'hA0, 0, 0, 5'h00, 32'h00, 0, 1, 6'b000000, 0, 0, 0, 0);
      tbl[1]  = row(0, 1, 0, 5'h13, 32'hA0, 0, 0, 5'h00, 32'h00, 0, 1, 6'b011000, 0, 3, 0, 32'hA0);
      tbl[2]  = row(0, 1, 0, 5'h13, 32'hA1, 0, 0, 5'h00, 32'h00, 0, 1, 6'b011000, 0, 3, 0, 32'hA1);
      tbl[3]  = row(0, 1, 0, 5'h13, 32'hA2, 0, 0, 5'h00, 32'h00, 0, 1, 6'b011000, 0, 3, 0, 32'hA2);
      tbl[4]  = row(0, 1, 1, 5'h13, 32'hA3, 0, 0, 5'h00, 32'h00, 0, 1, 6'b011001, 0, 3, 0, 32'hA3);
      tbl[5]  = row(0, 0, 0, 5'h00, 32'h00, 0, 0, 5'h00, 32'h00, 0, 1, 6'b000000, 0, 0, 0, 0);
      tbl[6]  = row(1, 1, 0, 5'h01, 32'hB0, 1, 0, 5'h02, 32'hC0, 1, 0, 6'b000000, 0, 0, 0, 0);
      tbl[7]  = row(0, 1, 0, 5'h01, 32'hB0, 1, 0, 5'h02, 32'hC0, 1, 0, 6'b101000, 1, 0, 32'hB0, 0);
      tbl[8]  = row(0, 1, 1, 5'h01, 32'hB1, 1, 0, 5'h02, 32'hC0, 1, 0, 6'b101010, 1, 0, 32'hB1, 0);
      tbl[9]  = row(0, 1, 1, 5'h01, 32'hD0, 1, 0, 5'h02, 32'hC0, 1, 0, 6'b000000, 0, 0, 0, 0);
      tbl[10] = row(0, 1, 1, 5'h01, 32'hD0, 1, 0, 5'h02, 32'hC0, 1, 0, 6'b100100, 2, 0, 32'hC0, 0);
      tbl[11] = row(0, 1, 1, 5'h01, 32'hD0, 1, 1, 5'h02, 32'hC1, 1, 0, 6'b100110, 2, 0, 32'hC1, 0);
      tbl[12] = row(0, 1, 1, 5'h01, 32'hD0, 0, 0, 5'h00, 32'h00, 1, 0, 6'b000000, 0, 0, 0, 0);
      tbl[13] = row(0, 1, 1, 5'h01, 32'hD0, 0, 0, 5'h00, 32'h00, 1, 0, 6'b101010, 1, 0, 32'hD0, 0);
      tbl[14] = row(0, 0, 0, 5'h00, 32'h00, 0, 0, 5'h00, 32'h00, 1, 0, 6'b000000, 0, 0, 0, 0);
      tbl[15] = row(0, 1, 0, 5'h05, 32'hF0, 0, 0, 5'h00, 32'h00, 1, 0, 6'b000000, 0, 0, 0, 0);
      tbl[16] = row(0, 1, 0, 5'h05, 32'hF0, 0, 0, 5'h00, 32'h00, 1, 0, 6'b101000, 5, 0, 32'hF0, 0);
      tbl[17] = row(0, 0, 0, 5'h05, 32'hF1, 0, 0, 5'h00, 32'h00, 1, 0, 6'b001000, 5, 0, 32'hF1, 0);
      tbl[18] = row(0, 1, 0, 5'h05, 32'hF1, 0, 0, 5'h00, 32'h00, 0, 0, 6'b100000, 5, 0, 32'hF1, 0);
      tbl[19] = row(0, 1, 0, 5'h05, 32'hF1, 0, 0, 5'h00, 32'h00, 0, 0, 6'b100000, 5, 0, 32'hF1, 0);
      tbl[20] = row(0, 1, 0, 5'h05, 32'hF1, 0, 0, 5'h00, 32'h00, 1, 0, 6'b101000, 5, 0, 32'hF1, 0);
      tbl[21] = row(0, 1, 1, 5'h05, 32'hF2, 0, 0, 5'h00, 32'h00, 1, 0, 6'b101010, 5, 0, 32'hF2, 0);
      tbl[22] = row(0, 0, 0, 5'h00, 32'h00, 0, 0, 5'h00, 32'h00, 1, 0, 6'b000000, 0, 0, 0, 0);

      for (int i = 0; i < NRows; i++) begin
         if (tbl[i].rb) do_reset();
         rvalid_s0 = tbl[i].v0; rlast_s0 = tbl[i].l0; rid_s0 = tbl[i].i0; rdata_s0 = tbl[i].d0;
         rvalid_s1 = tbl[i].v1; rlast_s1 = tbl[i].l1; rid_s1 = tbl[i].i1; rdata_s1 = tbl[i].d1;
         rready_m0 = tbl[i].r0; rready_m1 = tbl[i].r1;
         #3;
         chk($sformatf("vec%0d", i),
             {rvalid_m0, rvalid_m1, rready_s0, rready_s1, rlast_m0, rlast_m1, rid_m0, rid_m1,
              rdata_m0, rdata_m1},
             {tbl[i].ctl, tbl[i].ei0, tbl[i].ei1, tbl[i].ed0, tbl[i].ed1});
         @(posedge clk);
         #1;
      end

      // Reset in the middle of a burst, then a fresh grant to S1
      idle_inputs();
      do_reset();
      rvalid_s0 = 1'b1; rid_s0 = 5'h10; rdata_s0 = 32'h11; rready_m1 = 1'b1;
      @(posedge clk);
      #4 chk("rst_beat1", {rvalid_m0, rvalid_m1, rready_s0, rready_s1, rdata_m1}, {4'b0110, 32'h11});
      @(posedge clk);
      #1 rdata_s0 = 32'h22;
      #1 rst = 1'b0;
      #1 chk("rst_async", {rvalid_m0, rvalid_m1, rready_s0, rready_s1}, 4'b0000);
      idle_inputs();
      @(posedge clk);
      #1 rst = 1'b1;
      rvalid_s1 = 1'b1; rid_s1 = 5'h04; rdata_s1 = 32'h77; rlast_s1 = 1'b1; rready_m0 = 1'b1;
      #3 chk("rst_idle", {rvalid_m0, rvalid_m1, rready_s0, rready_s1}, 4'b0000);
      @(posedge clk);
      #4 chk("rst_regrant", {rvalid_m0, rvalid_m1, rready_s0, rready_s1, rid_m0, rdata_m0},
             {4'b1001, 4'h4, 32'h77});
      @(posedge clk);
      #1 idle_inputs();

      // RID drifting mid-burst
      do_reset();
      rvalid_s0 = 1'b1; rid_s0 = 5'h02; rdata_s0 = 32'h1; rready_m0 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rid_s0 = 5'h03; rdata_s0 = 32'h2;
      #3 chk("prot_rid_ok", prot_err, 1'b0);
      chk("prot_rid_pass", {rvalid_m0, rid_m0, rdata_m0}, {1'b1, 4'h3, 32'h2});
      @(posedge clk);
      #1 rlast_s0 = 1'b1; rdata_s0 = 32'h3;
      #3 chk("prot_rid_err", prot_err, ExpErr);
      @(posedge clk);
      #1 idle_inputs();
      repeat (3) @(posedge clk);
      #1 chk("prot_rid_sticky", prot_err, ExpErr);
      do_reset();
      #3 chk("prot_rst_clear", prot_err, 1'b0);

      // 257-beat burst: the 256th beat lacks RLAST
      rvalid_s0 = 1'b1; rid_s0 = 5'h00; rready_m0 = 1'b1;
      @(posedge clk);
      #1;
      for (int b = 1; b <= 257; b++) begin
         rlast_s0 = (b == 257); rdata_s0 = b;
         #3;
         if (b == 256) chk("prot_len_255", prot_err, 1'b0);
         if (b == 257) chk("prot_len_at256", {prot_err, rvalid_m0, rlast_m0}, {ExpErr, 2'b11});
         @(posedge clk);
         #1;
      end
      idle_inputs();
      #3 chk("prot_len_sticky", prot_err, ExpErr);

      // Randomized traffic against transaction-level rules
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sv[s] = 1'b0; sl[s] = 1'b0; sid[s] = '0; sd[s] = '0; sr[s] = '0;
         rem[s] = 0; bursts[s] = 0;
      end
      owner = -1;
      cyc = 0;
      while (cyc < 4000 && !(bursts[0] == NB && bursts[1] == NB)) begin
         cyc++;
         for (int s = 0; s < 2; s++) begin
            if (!sv[s]) begin
               if (rem[s] == 0 && bursts[s] < NB && $urandom_range(3) != 0) begin
                  rem[s] = $urandom_range(1, 4);
                  sid[s] = 5'($urandom);
               end
               if (rem[s] > 0 && $urandom_range(3) != 0) begin
                  sv[s] = 1'b1; sd[s] = $urandom; sr[s] = 2'($urandom); sl[s] = (rem[s] == 1);
               end
            end
         end
         rvalid_s0 = sv[0]; rid_s0 = sid[0]; rdata_s0 = sd[0]; rresp_s0 = sr[0]; rlast_s0 = sl[0];
         rvalid_s1 = sv[1]; rid_s1 = sid[1]; rdata_s1 = sd[1]; rresp_s1 = sr[1]; rlast_s1 = sl[1];
         rready_m0 = ($urandom_range(3) != 0);
         rready_m1 = ($urandom_range(3) != 0);
         #3;
         hs_s[0] = sv[0] & rready_s0;
         hs_s[1] = sv[1] & rready_s1;
         mhs[0]  = rvalid_m0 & rready_m0;
         mhs[1]  = rvalid_m1 & rready_m1;
         for (int m = 0; m < 2; m++) begin
            if (mhs[m]) begin
               src = -1;
               for (int s = 0; s < 2; s++) if (hs_s[s] && sid[s][4] == m[0]) src = s;
               chk("rand_src", src >= 0, 1'b1);
               if (src >= 0) begin
                  got_beat = (m == 0) ? {rid_m0, rdata_m0, rresp_m0, rlast_m0}
                                      : {rid_m1, rdata_m1, rresp_m1, rlast_m1};
                  chk("rand_beat", got_beat, {sid[src][3:0], sd[src], sr[src], sl[src]});
               end
            end
         end
         for (int s = 0; s < 2; s++) begin
            if (hs_s[s]) begin
               chk("rand_fwd", mhs[sid[s][4]], 1'b1);
               if (owner >= 0) chk("rand_lock", s, owner);
               owner = sl[s] ? -1 : s;
            end
         end
         @(posedge clk);
         #1;
         for (int s = 0; s < 2; s++) begin
            if (hs_s[s]) begin
               sv[s] = 1'b0;
               rem[s]--;
               if (rem[s] == 0) bursts[s]++;
            end
         end
      end
      chk("rand_drain", bursts[0] + bursts[1], 2 * NB);
      chk("rand_prot", prot_err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
